phase_frame_buffer: RTL

- Sits directly downstream of the arctan2 phase stage. Collects per-channel phase words as they arrive, in any order and in bursts, tagged by channel address.
- Assembles them into complete VECTOR_LEN-channel frames in a ping-pong BRAM.
- Hands each finished frame to the readout/DoA logic through a frame_avail / frame_ack handshake.
- Write side never stalls; overflow is flagged, not back-pressured.

---
 rtl/phase_frame_buffer_pkg.sv | 16 +
 rtl/phase_frame_buffer_bram.sv | 32 +++
 rtl/phase_frame_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/phase_frame_buffer_pkg.sv
// Shared types and constants for the phase frame buffer.
// Address width helper, frame id width and bank select type.
package phase_frame_buffer_pkg;

  localparam int FRAME_ID_WIDTH = 16;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_t;

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phase_frame_buffer_bram.sv
// bram_infer: simple dual-port RAM, one write port, one registered read port.
// Ports: we/waddr/wdata write side; re/raddr in, rdata_o out (1-cycle latency).
module bram_infer #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/phase_frame_buffer.sv
// Ping-pong frame assembler for per-channel phase words with avail/ack readout.
// Ports: addr_in/phase_in/phase_valid write side; rd_en/rd_addr -> rd_data/rd_valid;
// frame_avail/frame_ack handshake; frame_done pulse; sticky overflow; frame_id.
// Optional: PHASE_FRAME_ID_EN builds the 16-bit frame counter behind frame_id.
module phase_frame_buffer
  import phase_frame_buffer_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int VECTOR_LEN = 512,
  parameter int ADDR_WIDTH = addr_w(VECTOR_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     addr_in,
  input  logic [DIN_WIDTH-1:0]      phase_in,
  input  logic                      phase_valid,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DIN_WIDTH-1:0]      rd_data,
  output logic                      rd_valid,
  output logic                      frame_avail,
  input  logic                      frame_ack,
  output logic                      frame_done,
  output logic                      overflow,
  output logic [FRAME_ID_WIDTH-1:0] frame_id
);

  bank_t                 wr_bank_q, wr_bank_d;
  logic [VECTOR_LEN-1:0] seen_q, seen_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  avail_q, avail_d;
  logic                  done_q;
  logic                  ovf_q;
  logic                  rvalid_q;

  logic uniq;
  logic complete;
  logic swap;

  assign uniq     = phase_valid & ~seen_q[addr_in];
  assign complete = uniq &
                    (count_q == ADDR_WIDTH'(VECTOR_LEN - 1));
  // An ack in the completing cycle frees the read bank in time.
  assign swap     = complete & (~avail_q | frame_ack);

  always_comb begin
    seen_d    = seen_q;
    count_d   = count_q;
    wr_bank_d = wr_bank_q;
    avail_d   = avail_q;
    if (complete) begin
      seen_d  = '0;
      count_d = '0;
    end else if (uniq) begin
      seen_d[addr_in] = 1'b1;
      count_d = count_q + ADDR_WIDTH'(1);
    end
    if (swap) begin
      wr_bank_d = bank_t'(~wr_bank_q);
      avail_d   = 1'b1;
    end else if (frame_ack) begin
      avail_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= BANK_0;
      seen_q    <= '0;
      count_q   <= '0;
      avail_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      seen_q    <= seen_d;
      count_q   <= count_d;
      avail_q   <= avail_d;
      done_q    <= swap;
      ovf_q     <= ovf_q | (complete & ~swap);
      rvalid_q  <= rd_en & avail_q;
    end
  end

  bram_infer #(
    .DW(DIN_WIDTH),
    .AW(ADDR_WIDTH + 1)
  ) u_bram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (phase_valid),
    .waddr_i ({wr_bank_q, addr_in}),
    .wdata_i (phase_in),
    .re_i    (rd_en),
    .raddr_i ({~wr_bank_q, rd_addr}),
    .rdata_o (rd_data)
  );

  assign rd_valid    = rvalid_q;
  assign frame_avail = avail_q;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;

`ifdef PHASE_FRAME_ID_EN
  logic [FRAME_ID_WIDTH-1:0] fcnt_q;
  logic [FRAME_ID_WIDTH-1:0] fid_q;

  // fid takes the pre-increment count, so the first frame is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      fid_q  <= '0;
    end else if (swap) begin
      fcnt_q <= fcnt_q + FRAME_ID_WIDTH'(1);
      fid_q  <= fcnt_q;
    end
  end

  assign frame_id = fid_q;
`else
  assign frame_id = '0;
`endif

endmodule
